tmma_seq: RTL and testbench
===========================

TMMA_SEQ -- requirements
Module: tmma_seq

Interface
REQ-001 SHALL have parameter ARRAY_N, default 4, meaning PE rows = PE columns in the driven array.
REQ-002 SHALL have parameter CNT_W, default `TMMA_CNT_WIDTH, meaning width of each per-lane k-index count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  request to run one TMMA tile.
REQ-006 SHALL have port k_len_i  input  CNT_W  reduction length K, sampled only at acceptance.
REQ-007 SHALL have port hold_i  input  1  operand-not-ready stall, honored only in FEED.
REQ-008 SHALL have port left_valid_o  output  ARRAY_N  per-row left_data_valid for column-0 PEs.
REQ-009 SHALL have port left_cnt_o  output  ARRAY_N*CNT_W  per-row left_data_cnt; row r occupies bits [r*CNT_W +: CNT_W].
REQ-010 SHALL have port top_valid_o  output  ARRAY_N  per-column top_data_valid for row-0 PEs.
REQ-011 SHALL have port top_cnt_o  output  ARRAY_N*CNT_W  per-column top_data_cnt, packed as left_cnt_o.
REQ-012 SHALL have port storec_o  output  ARRAY_N  per-column top_storec_valid.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle tile-complete pulse.

Function
REQ-015 SHALL implement states IDLE, FEED, DRAIN, STORE; all outputs registered.
REQ-016 SHALL accept start_i only in IDLE; start_i while busy_o=1 SHALL be ignored.
REQ-017 On acceptance with k_len_i!=0, SHALL latch K and enter FEED next cycle with step counter t=0.
REQ-018 On acceptance with k_len_i==0, SHALL stay IDLE and pulse done_o the next cycle; it SHALL assert no valids.
REQ-019 In FEED, lane i (row i and column i) SHALL have valid=1 and cnt=t-i iff i <= t <= i+K-1; otherwise valid=0 and cnt=0.
REQ-020 In FEED with hold_i=1, t SHALL freeze and all valid bits SHALL be 0 that cycle; cnt values SHALL be held.
REQ-021 In FEED, t SHALL increment by 1 per non-held cycle; FEED SHALL end after the cycle with t=K+ARRAY_N-2, then enter DRAIN.
REQ-022 The t counter SHALL be wide enough for K_max+ARRAY_N-2 without wrap; K=2^CNT_W-1 SHALL work.
REQ-023 DRAIN SHALL last exactly ARRAY_N cycles with all valids 0; hold_i SHALL be ignored.
REQ-024 On the first STORE cycle storec_o SHALL be all-ones for exactly one cycle; STORE SHALL last ARRAY_N cycles, then the FSM SHALL return to IDLE.
REQ-025 done_o SHALL pulse for one cycle on the first IDLE cycle after STORE; start_i sampled in that same cycle SHALL be accepted.
REQ-026 busy_o SHALL be 1 in FEED, DRAIN and STORE, and 0 in IDLE, including during the done_o cycle.

Reset
REQ-027 On rst_n=0, SHALL immediately, without waiting for a clock edge, force state IDLE, t=0, and every output (valids, cnts, storec_o, busy_o, done_o) to 0.
REQ-028 Reset asserted mid-tile SHALL abandon the tile, produce no done_o, and accept a new start_i on the first edge after release.

Verification (ARRAY_N=4; cycle 1 = first cycle after acceptance)
REQ-029 start_i=1, K=3, no hold -> the bench SHALL check:
- left_valid_o/top_valid_o = 0001,0011,0111,1110,1100,1000 over cycles 1-6.
- Row 3 cnt = 0,1,2 in cycles 4-6.
- storec_o=1111 in cycle 11 only.
- busy_o high in cycles 1-14; done_o in cycle 15.
REQ-030 K=3 with hold_i=1 in cycle 3 -> the bench SHALL check:
- All valids are 0 in cycle 3.
- Cycle 4 repeats the t=2 pattern (0111).
- All later events shift by +1, with done_o in cycle 16.
REQ-031 k_len_i=0 -> the bench SHALL check:
- done_o is high in cycle 1.
- busy_o and all valids stay 0.
REQ-032 start_i held high continuously with K=1 -> the bench SHALL check:
- Back-to-back tiles run; the second tile's cycle 1 immediately follows the done_o cycle.
- start_i pulses during busy_o are ignored.
REQ-033 rst_n low in cycle 8 (DRAIN) of a K=3 tile -> the bench SHALL check:
- All outputs are 0 asynchronously.
- No done_o is produced.
- A new start_i after release runs a full tile.
REQ-034 K=2^CNT_W-1 -> the bench SHALL check:
- Lane 0 cnt counts 0..K-1 without wrap.
- FEED lasts K+3 cycles.

Source files
------------

// File: rtl/tmma_seq.sv
// Tile sequencer for an ARRAY_N x ARRAY_N systolic TMMA array: skews per-lane
// operand valids/k-indices through FEED, then waits out DRAIN and STORE.
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif

module tmma_lane #(
   parameter int CNT_W = 8,
   parameter int T_W   = 11,
   parameter int LANE  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic             clr,
   input  logic [T_W-1:0]   step,
   input  logic [CNT_W-1:0] k,
   output logic             valid,
   output logic [CNT_W-1:0] cnt
);
   logic [T_W-1:0] rel;
   logic           in_win;

   assign rel    = step - T_W'(LANE);
   assign in_win = (step >= T_W'(LANE)) && (rel < T_W'(k));

   // Neither ld nor clr means a held FEED cycle: drop valid, keep the index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         cnt   <= '0;
      end else if (clr) begin
         valid <= 1'b0;
         cnt   <= '0;
      end else if (ld) begin
         valid <= in_win;
         cnt   <= in_win ? rel[CNT_W-1:0] : '0;
      end else begin
         valid <= 1'b0;
      end
   end
endmodule

module tmma_seq #(
   parameter int ARRAY_N = 4,
   parameter int CNT_W   = `TMMA_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [CNT_W-1:0]         k_len_i,
   input  logic                     hold_i,
   output logic [ARRAY_N-1:0]       left_valid_o,
   output logic [ARRAY_N*CNT_W-1:0] left_cnt_o,
   output logic [ARRAY_N-1:0]       top_valid_o,
   output logic [ARRAY_N*CNT_W-1:0] top_cnt_o,
   output logic [ARRAY_N-1:0]       storec_o,
   output logic                     busy_o,
   output logic                     done_o
);
   localparam int T_W = CNT_W + $clog2(ARRAY_N) + 1;
   localparam int P_W = $clog2(ARRAY_N) + 1;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, STORE} state_t;

   state_t                          state;
   logic [T_W-1:0]                  t;
   logic [CNT_W-1:0]                k_q;
   logic [P_W-1:0]                  ph;
   logic [T_W-1:0]                  last;
   logic                            ld, clr;
   logic [T_W-1:0]                  step;
   logic [CNT_W-1:0]                k_eff;
   logic [ARRAY_N-1:0]              lane_v;
   logic [ARRAY_N-1:0][CNT_W-1:0]   lane_c;

   // t is the next step to emit; steps 0..K+N-2 cover every lane's window.
   assign last  = T_W'(k_q) + T_W'(ARRAY_N - 1);
   assign k_eff = (state == IDLE) ? k_len_i : k_q;

   always_comb begin
      ld   = 1'b0;
      clr  = 1'b0;
      step = t;
      case (state)
         IDLE: begin
            step = '0;
            if (start_i && k_len_i != '0) ld = 1'b1;
            else                          clr = 1'b1;
         end
         FEED: begin
            if (!hold_i) begin
               if (t < last) ld  = 1'b1;
               else          clr = 1'b1;
            end
         end
         default: clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         t        <= '0;
         k_q      <= '0;
         ph       <= '0;
         storec_o <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o   <= 1'b0;
         storec_o <= '0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (k_len_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     k_q    <= k_len_i;
                     t      <= T_W'(1);
                     state  <= FEED;
                     busy_o <= 1'b1;
                  end
               end
            end
            FEED: begin
               if (!hold_i) begin
                  if (t < last) begin
                     t <= t + T_W'(1);
                  end else begin
                     state <= DRAIN;
                     ph    <= '0;
                  end
               end
            end
            DRAIN: begin
               if (ph == P_W'(ARRAY_N - 1)) begin
                  state    <= STORE;
                  ph       <= '0;
                  storec_o <= '1;
               end else begin
                  ph <= ph + P_W'(1);
               end
            end
            STORE: begin
               if (ph == P_W'(ARRAY_N - 1)) begin
                  state  <= IDLE;
                  t      <= '0;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  ph <= ph + P_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
      tmma_lane #(.CNT_W(CNT_W), .T_W(T_W), .LANE(g)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld    (ld),
         .clr   (clr),
         .step  (step),
         .k     (k_eff),
         .valid (lane_v[g]),
         .cnt   (lane_c[g])
      );
   end

   // Row i and column i share a skew, so both edges are fed from one lane.
   assign left_valid_o = lane_v;
   assign top_valid_o  = lane_v;
   assign left_cnt_o   = lane_c;
   assign top_cnt_o    = lane_c;
endmodule

// File: tb/tb_tmma_seq.sv
// Directed bench for tmma_seq (ARRAY_N=4); cycle c = c-th cycle after the
// accepting edge, sampled 1 time unit after its opening rising edge.
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif

module tb_tmma_seq;
   localparam int N  = 4;
   localparam int CW = `TMMA_CNT_WIDTH;
   localparam int KM = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n, start, hold;
   logic [CW-1:0]     k_len;
   logic [N-1:0]      left_v, top_v, storec;
   logic [N*CW-1:0]   left_c, top_c;
   logic              busy, done;
   int                n_tests = 0;
   int                n_fail  = 0;

   tmma_seq #(.ARRAY_N(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .k_len_i(k_len), .hold_i(hold),
      .left_valid_o(left_v), .left_cnt_o(left_c), .top_valid_o(top_v),
      .top_cnt_o(top_c), .storec_o(storec), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hand-derived K=3 lane valid pattern per cycle.
   function automatic logic [N-1:0] exp_k3(input int c);
      case (c)
         1: return 4'b0001;
         2: return 4'b0011;
         3: return 4'b0111;
         4: return 4'b1110;
         5: return 4'b1100;
         6: return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic test_reset;
      #3;
      n_tests++;
      if ({left_v, top_v, left_c, top_c, storec, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b/%b storec=%b busy=%b done=%b, want all 0",
                  left_v, top_v, storec, busy, done);
      end
      tick; tick;
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [CW-1:0] ec;
      k_len = 3; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) begin
            hold = (c >= 8 && c <= 11);  // hold during DRAIN must be ignored
            tick;
            hold = 1'b0;
         end
         n_tests++;
         if (left_v !== exp_k3(c) || top_v !== exp_k3(c)) begin
            n_fail++;
            $display("FAIL basic_valid c=%0d: got %b/%b want %b", c, left_v, top_v, exp_k3(c));
         end
         n_tests++;
         if (storec !== ((c == 11) ? 4'b1111 : 4'b0000)) begin
            n_fail++;
            $display("FAIL basic_storec c=%0d: got %b", c, storec);
         end
         n_tests++;
         if (busy !== (c <= 14) || done !== (c == 15)) begin
            n_fail++;
            $display("FAIL basic_busy_done c=%0d: got busy=%b done=%b", c, busy, done);
         end
         if (c >= 4 && c <= 6) begin
            ec = CW'(c - 4);
            n_tests++;
            if (left_c[3*CW +: CW] !== ec || top_c[3*CW +: CW] !== ec) begin
               n_fail++;
               $display("FAIL basic_row3_cnt c=%0d: got %0d/%0d want %0d",
                        c, left_c[3*CW +: CW], top_c[3*CW +: CW], ec);
            end
         end
         if (c <= 3) begin
            ec = CW'(c - 1);
            n_tests++;
            if (left_c[CW-1:0] !== ec) begin
               n_fail++;
               $display("FAIL basic_row0_cnt c=%0d: got %0d want %0d", c, left_c[CW-1:0], ec);
            end
         end
      end
   endtask

   task automatic test_hold;
      logic [N-1:0] ev;
      k_len = 3; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (c > 1) begin
            hold = (c == 3);
            tick;
            hold = 1'b0;
         end
         ev = (c < 3) ? exp_k3(c) : (c == 3) ? 4'b0000 : exp_k3(c - 1);
         n_tests++;
         if (left_v !== ev || top_v !== ev) begin
            n_fail++;
            $display("FAIL hold_valid c=%0d: got %b/%b want %b", c, left_v, top_v, ev);
         end
         if (c == 3 || c == 4) begin
            n_tests++;
            if (left_c[CW-1:0] !== CW'(c - 2) || left_c[2*CW-1:CW] !== CW'(c - 3)) begin
               n_fail++;
               $display("FAIL hold_cnt c=%0d: got lane0=%0d lane1=%0d want %0d %0d",
                        c, left_c[CW-1:0], left_c[2*CW-1:CW], c - 2, c - 3);
            end
         end
         n_tests++;
         if (storec !== ((c == 12) ? 4'b1111 : 4'b0000) || busy !== (c <= 15) || done !== (c == 16)) begin
            n_fail++;
            $display("FAIL hold_timing c=%0d: got storec=%b busy=%b done=%b", c, storec, busy, done);
         end
      end
   endtask

   task automatic test_k0;
      k_len = 0; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         if (c > 1) tick;
         n_tests++;
         if (done !== (c == 1) || busy !== 1'b0 || left_v !== '0 || top_v !== '0) begin
            n_fail++;
            $display("FAIL k0 c=%0d: got done=%b busy=%b v=%b/%b", c, done, busy, left_v, top_v);
         end
      end
   endtask

   task automatic test_back_to_back;
      int p;
      logic [N-1:0] ev;
      k_len = 1; start = 1'b1;
      tick;
      for (int c = 1; c <= 26; c++) begin
         if (c > 1) tick;
         p  = ((c - 1) % 13) + 1;
         ev = (p <= 4) ? N'(1 << (p - 1)) : '0;
         n_tests++;
         if (left_v !== ev || done !== (p == 13) || busy !== (p != 13)) begin
            n_fail++;
            $display("FAIL b2b c=%0d: got v=%b done=%b busy=%b want v=%b", c, left_v, done, busy, ev);
         end
      end
      start = 1'b0;
      tick;
      n_tests++;
      if (busy !== 1'b0 || left_v !== '0) begin
         n_fail++;
         $display("FAIL b2b_stop: got busy=%b v=%b want 0", busy, left_v);
      end
   endtask

   task automatic test_reset_mid;
      k_len = 3; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 2; c <= 8; c++) tick;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre_busy: got %b want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({left_v, top_v, left_c, top_c, storec, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL mid_async_clear: got v=%b busy=%b done=%b storec=%b", left_v, busy, done, storec);
      end
      tick;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick;
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_done i=%0d: got done=%b busy=%b", c, done, busy);
         end
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) tick;
         n_tests++;
         if (left_v !== exp_k3(c) || storec !== ((c == 11) ? 4'b1111 : 4'b0000) ||
             busy !== (c <= 14) || done !== (c == 15)) begin
            n_fail++;
            $display("FAIL mid_rerun c=%0d: got v=%b storec=%b busy=%b done=%b", c, left_v, storec, busy, done);
         end
      end
   endtask

   task automatic test_kmax;
      logic [CW-1:0] ec;
      k_len = CW'(KM); start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= KM + 12; c++) begin
         if (c > 1) tick;
         ec = (c <= KM) ? CW'(c - 1) : '0;
         n_tests++;
         if (left_v[0] !== (c <= KM) || left_c[CW-1:0] !== ec) begin
            n_fail++;
            $display("FAIL kmax_lane0 c=%0d: got v=%b cnt=%0d want %0d", c, left_v[0], left_c[CW-1:0], ec);
         end
         n_tests++;
         if (left_v[3] !== (c >= 4 && c <= KM + 3)) begin
            n_fail++;
            $display("FAIL kmax_lane3 c=%0d: got v=%b", c, left_v[3]);
         end
         if (c == KM + 3) begin
            n_tests++;
            if (left_v !== 4'b1000 || left_c[3*CW +: CW] !== CW'(KM - 1)) begin
               n_fail++;
               $display("FAIL kmax_last_feed: got v=%b cnt3=%0d want 1000 %0d", left_v, left_c[3*CW +: CW], KM - 1);
            end
         end
         n_tests++;
         if (storec !== ((c == KM + 8) ? 4'b1111 : 4'b0000) || busy !== (c <= KM + 11) || done !== (c == KM + 12)) begin
            n_fail++;
            $display("FAIL kmax_timing c=%0d: got storec=%b busy=%b done=%b", c, storec, busy, done);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; hold = 1'b0; k_len = '0;
      test_reset;
      test_basic;
      tick;
      test_hold;
      tick;
      test_k0;
      tick;
      test_back_to_back;
      tick;
      test_reset_mid;
      tick;
      test_kmax;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
